i2c_master_reader: RTL and testbench

- Single-master I2C controller that polls the quadrature counter slave from the host CPLD/FPGA side.
- Two transaction types: write a one-byte command, or read N bytes.
- Read bytes are returned one at a time with a valid strobe.
- Drives SCL and SDA open-drain (0 or z only); no clock-stretching support and no multi-master arbitration.

---
 rtl/i2c_master_reader.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_i2c_master_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_reader.sv
// i2c_master_reader: single-master I2C controller that writes a one-byte
// command or reads N bytes from a fixed 7-bit slave address.
// SCL and SDA are open-drain: the controller only ever pulls them low or
// releases them. There is no clock stretching and no multi-master arbitration.
`timescale 1ns/1ps
module i2c_master_reader #(
    parameter int unsigned CLKDIV    = 250,
    parameter logic [6:0]  SLAVEADDR = 7'b1110010
) (
    input  logic       CLCK,
    input  logic       RST,
    input  logic       GO,
    input  logic       RW,
    input  logic [7:0] CMD,
    input  logic [3:0] LEN,
    output logic [7:0] RDATA,
    output logic       RVALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       NACK,
    inout  wire        SCL,
    inout  wire        SDA
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_AACK  = 4'd3,
        ST_WBYTE = 4'd4,
        ST_WACK  = 4'd5,
        ST_RBYTE = 4'd6,
        ST_MACK  = 4'd7,
        ST_STOP  = 4'd8
    } state_t;

    localparam logic [9:0] DIV_LAST = 10'(CLKDIV - 1);

    state_t      state_r, state_n;
    logic [9:0]  div_r, div_n;
    logic [1:0]  q_r, q_n;
    logic [2:0]  bit_r, bit_n;
    logic [7:0]  tx_r, tx_n;
    logic [7:0]  cmd_r, cmd_n;
    logic [7:0]  rx_r, rx_n;
    logic [3:0]  rem_r, rem_n;
    logic        rw_r, rw_n;
    logic        nack_r, nack_n;
    logic        busy_r, busy_n;
    logic        done_r, done_n;
    logic        rvalid_r, rvalid_n;
    logic [7:0]  rdata_r, rdata_n;
    logic        scl_low_r, sda_low_r;
    logic        sda_meta_r, sda_sync_r;
    logic        tick_s;
    logic [1:0]  drive_s;

    // Line drive {scl_low, sda_low} for a given state and quarter phase.
    // Data bits use q0/q3 with SCL low and q1/q2 with SCL released.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] q,
                                              input logic tx_msb, input logic ack);
        logic scl_low;
        logic sda_low;
        scl_low = (q == 2'd0) || (q == 2'd3);
        sda_low = 1'b0;
        case (st)
            ST_START: begin
                scl_low = (q == 2'd1);
                sda_low = 1'b1;
            end
            ST_ADDR, ST_WBYTE: sda_low = ~tx_msb;
            ST_AACK, ST_WACK, ST_RBYTE: sda_low = 1'b0;
            ST_MACK: sda_low = ack;
            ST_STOP: begin
                scl_low = (q == 2'd0);
                sda_low = (q != 2'd2);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
        return {scl_low, sda_low};
    endfunction

    assign tick_s  = (state_r != ST_IDLE) && (div_r == DIV_LAST);
    // Drives are computed from the next state so the registered lines
    // change on the same edge as the state they belong to.
    assign drive_s = line_drive(state_n, q_n, tx_n[7], rem_n > 4'd1);

    assign SCL    = scl_low_r ? 1'b0 : 1'bz;
    assign SDA    = sda_low_r ? 1'b0 : 1'bz;
    assign RDATA  = rdata_r;
    assign RVALID = rvalid_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign NACK   = nack_r;

    // Two-flop synchronizer on the incoming SDA level.
    always_ff @(posedge CLCK or posedge RST) begin
        if (RST) begin
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            sda_meta_r <= SDA;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Next-state, phase, shift-register and output-strobe logic.
    always_comb begin
        state_n  = state_r;
        q_n      = q_r;
        bit_n    = bit_r;
        tx_n     = tx_r;
        cmd_n    = cmd_r;
        rx_n     = rx_r;
        rem_n    = rem_r;
        rw_n     = rw_r;
        nack_n   = nack_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        rvalid_n = 1'b0;
        rdata_n  = rdata_r;
        if ((state_r == ST_IDLE) || tick_s) begin
            div_n = 10'd0;
        end else begin
            div_n = div_r + 10'd1;
        end
        case (state_r)
            ST_IDLE: begin
                if (GO) begin
                    rw_n    = RW;
                    cmd_n   = CMD;
                    tx_n    = {SLAVEADDR, RW};
                    rem_n   = (LEN == 4'd0) ? 4'd1 : LEN;
                    nack_n  = 1'b0;
                    busy_n  = 1'b1;
                    q_n     = 2'd0;
                    bit_n   = 3'd7;
                    state_n = ST_START;
                end else begin
                    busy_n = 1'b0;
                end
            end
            ST_START: begin
                if (tick_s && (q_r == 2'd1)) begin
                    q_n     = 2'd0;
                    bit_n   = 3'd7;
                    state_n = ST_ADDR;
                end else if (tick_s) begin
                    q_n = q_r + 2'd1;
                end else begin
                    q_n = q_r;
                end
            end
            ST_ADDR, ST_WBYTE: begin
                if (tick_s && (q_r == 2'd3)) begin
                    q_n  = 2'd0;
                    tx_n = {tx_r[6:0], 1'b0};
                    if (bit_r == 3'd0) begin
                        state_n = (state_r == ST_ADDR) ? ST_AACK : ST_WACK;
                    end else begin
                        bit_n = bit_r - 3'd1;
                    end
                end else if (tick_s) begin
                    q_n = q_r + 2'd1;
                end else begin
                    q_n = q_r;
                end
            end
            ST_AACK, ST_WACK: begin
                if (tick_s && (q_r == 2'd2)) begin
                    q_n = 2'd3;
                    if (sda_sync_r) begin
                        nack_n = 1'b1;
                    end else begin
                        nack_n = nack_r;
                    end
                end else if (tick_s && (q_r == 2'd3)) begin
                    q_n   = 2'd0;
                    bit_n = 3'd7;
                    if ((state_r == ST_WACK) || nack_r) begin
                        state_n = ST_STOP;
                    end else if (rw_r) begin
                        state_n = ST_RBYTE;
                    end else begin
                        tx_n    = cmd_r;
                        state_n = ST_WBYTE;
                    end
                end else if (tick_s) begin
                    q_n = q_r + 2'd1;
                end else begin
                    q_n = q_r;
                end
            end
            ST_RBYTE: begin
                if (tick_s && (q_r == 2'd2)) begin
                    q_n  = 2'd3;
                    rx_n = {rx_r[6:0], sda_sync_r};
                end else if (tick_s && (q_r == 2'd3)) begin
                    q_n = 2'd0;
                    if (bit_r == 3'd0) begin
                        rdata_n  = rx_r;
                        rvalid_n = 1'b1;
                        state_n  = ST_MACK;
                    end else begin
                        bit_n = bit_r - 3'd1;
                    end
                end else if (tick_s) begin
                    q_n = q_r + 2'd1;
                end else begin
                    q_n = q_r;
                end
            end
            ST_MACK: begin
                if (tick_s && (q_r == 2'd3)) begin
                    q_n = 2'd0;
                    if (rem_r > 4'd1) begin
                        rem_n   = rem_r - 4'd1;
                        bit_n   = 3'd7;
                        state_n = ST_RBYTE;
                    end else begin
                        state_n = ST_STOP;
                    end
                end else if (tick_s) begin
                    q_n = q_r + 2'd1;
                end else begin
                    q_n = q_r;
                end
            end
            ST_STOP: begin
                if (tick_s && (q_r == 2'd2)) begin
                    q_n     = 2'd0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end else if (tick_s) begin
                    q_n = q_r + 2'd1;
                end else begin
                    q_n = q_r;
                end
            end
            default: begin
                q_n     = 2'd0;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset releases both lines at once.
    always_ff @(posedge CLCK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            div_r     <= 10'd0;
            q_r       <= 2'd0;
            bit_r     <= 3'd0;
            tx_r      <= 8'd0;
            cmd_r     <= 8'd0;
            rx_r      <= 8'd0;
            rem_r     <= 4'd0;
            rw_r      <= 1'b0;
            nack_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 8'd0;
            scl_low_r <= 1'b0;
            sda_low_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            div_r     <= div_n;
            q_r       <= q_n;
            bit_r     <= bit_n;
            tx_r      <= tx_n;
            cmd_r     <= cmd_n;
            rx_r      <= rx_n;
            rem_r     <= rem_n;
            rw_r      <= rw_n;
            nack_r    <= nack_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            rvalid_r  <= rvalid_n;
            rdata_r   <= rdata_n;
            scl_low_r <= drive_s[1];
            sda_low_r <= drive_s[0];
        end
    end

endmodule

// File: tb/tb_i2c_master_reader.sv
// Self-checking bench for i2c_master_reader with a behavioural I2C slave.
`timescale 1ns/1ps
module tb_i2c_master_reader;
    localparam int         CLKDIV   = 4;
    localparam logic [6:0] DUT_ADDR = 7'h72;
    localparam int         LIMIT    = 20000;

    logic       CLCK, RST, GO, RW;
    logic [7:0] CMD;
    logic [3:0] LEN;
    logic [7:0] RDATA;
    logic       RVALID, BUSY, DONE, NACK;
    wire        SCL, SDA;

    pullup (SCL);
    pullup (SDA);

    logic       slave_sda_low;
    logic       slave_quiet;
    assign SDA = (slave_sda_low && !slave_quiet) ? 1'b0 : 1'bz;

    i2c_master_reader #(.CLKDIV(CLKDIV), .SLAVEADDR(DUT_ADDR)) dut (
        .CLCK(CLCK), .RST(RST), .GO(GO), .RW(RW), .CMD(CMD), .LEN(LEN),
        .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY), .DONE(DONE), .NACK(NACK),
        .SCL(SCL), .SDA(SDA)
    );

    int checks = 0;
    int errors = 0;

    // slave configuration (written by the main test) and observations
    logic [6:0] sl_addr;
    logic [7:0] rd_data [16];
    logic       bits_q [$];
    logic       exp_q  [$];
    int         stop_cnt = 0;

    // clock-domain monitor counters
    int         busy_cyc = 0, done_cnt = 0, rvalid_cnt = 0, overlap = 0;
    logic [7:0] rx_q [$];

    typedef struct {
        logic       rw;
        logic [7:0] cmd;
        logic [3:0] len;
        logic [6:0] saddr;
        logic       exp_nack;
        int         exp_nrx;
    } vec_t;
    vec_t tab [7];

    initial CLCK = 1'b0;
    always #5 CLCK = ~CLCK;

    initial begin
        #900000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    // Behavioural slave: START/STOP detection, bit capture on SCL rise,
    // ACK / read-data drive after SCL fall.
    initial begin
        logic ps, pd, cs, cd, b;
        logic in_xfer, addressed, sl_rd, mnack;
        logic [7:0] sh, cur;
        int frame_bit, byte_i;
        slave_sda_low = 1'b0;
        in_xfer = 1'b0; addressed = 1'b0; sl_rd = 1'b0; mnack = 1'b0;
        sh = 8'd0; frame_bit = 0; byte_i = 0;
        ps = 1'b1; pd = 1'b1;
        forever begin
            @(SCL or SDA);
            cs = (SCL !== 1'b0);
            cd = (SDA !== 1'b0);
            if (ps && cs && pd && !cd) begin
                in_xfer = 1'b1; frame_bit = 0; byte_i = 0;
                addressed = 1'b0; sl_rd = 1'b0; mnack = 1'b0;
                bits_q.delete();
                slave_sda_low = 1'b0;
            end else if (ps && cs && !pd && cd) begin
                // the STOP's own SCL rise was captured as a bit; drop it
                if (in_xfer && (bits_q.size() > 0)) void'(bits_q.pop_back());
                if (in_xfer) stop_cnt++;
                in_xfer = 1'b0;
                slave_sda_low = 1'b0;
            end else if (!ps && cs && in_xfer) begin
                b = cd;
                bits_q.push_back(b);
                if (frame_bit < 8) sh = {sh[6:0], b};
                else if ((byte_i > 0) && sl_rd && b) mnack = 1'b1;
                if (frame_bit == 8) begin
                    frame_bit = 0;
                    byte_i++;
                end else begin
                    frame_bit++;
                end
            end else if (ps && !cs && in_xfer) begin
                if (frame_bit == 8) begin
                    if (byte_i == 0) begin
                        addressed = (sh[7:1] == sl_addr);
                        sl_rd = sh[0];
                        slave_sda_low = addressed;
                    end else begin
                        slave_sda_low = addressed && !sl_rd;
                    end
                end else if (addressed && sl_rd && (byte_i >= 1) && (byte_i <= 16) && !mnack) begin
                    cur = rd_data[byte_i-1];
                    slave_sda_low = !cur[7-frame_bit];
                end else begin
                    slave_sda_low = 1'b0;
                end
            end
            ps = cs;
            pd = cd;
        end
    end

    // Output monitor sampled on the falling clock edge.
    initial begin
        forever begin
            @(negedge CLCK);
            if (BUSY === 1'b1) busy_cyc++;
            if (DONE === 1'b1) done_cnt++;
            if ((DONE === 1'b1) && (BUSY === 1'b1)) overlap++;
            if (RVALID === 1'b1) begin
                rvalid_cnt++;
                rx_q.push_back(RDATA);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int n_bytes(input logic [3:0] len);
        return (len == 4'd0) ? 1 : int'(len);
    endfunction

    // Reference: START 2 ticks, address+ack 9 bits, payload, STOP 3 ticks.
    function automatic int exp_ticks(input logic rw, input logic [3:0] len, input logic ack_ok);
        int t;
        t = 2 + 36 + 3;
        if (ack_ok) t = t + 36 * (rw ? n_bytes(len) : 1);
        return t;
    endfunction

    // Reference bit stream as seen on SDA at every SCL rise.
    task automatic build_stream(input logic rw, input logic [7:0] cmd, input logic [3:0] len,
                                input logic ack_ok);
        logic [7:0] ab;
        logic [7:0] d;
        int n;
        exp_q.delete();
        ab = {DUT_ADDR, rw};
        for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
        exp_q.push_back(!ack_ok);
        if (ack_ok && !rw) begin
            d = cmd;
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
            exp_q.push_back(1'b0);
        end else if (ack_ok) begin
            n = n_bytes(len);
            for (int k = 0; k < n; k++) begin
                d = rd_data[k];
                for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
                exp_q.push_back(k == n - 1);
            end
        end
    endtask

    task automatic pulse_go(input logic rw, input logic [7:0] cmd, input logic [3:0] len);
        RW = rw; CMD = cmd; LEN = len; GO = 1'b1;
        @(posedge CLCK);
        #1;
        GO = 1'b0;
        RW = 1'($urandom); CMD = 8'($urandom); LEN = 4'($urandom);
    endtask

    task automatic run_xfer(input string tag, input logic rw, input logic [7:0] cmd,
                            input logic [3:0] len, input logic [6:0] saddr,
                            input logic exp_nack, input int exp_nrx, input int inject_at);
        int done0, busy0, rv0, rx0, stop0, cyc, first;
        logic ack_ok;
        sl_addr = saddr;
        ack_ok = (saddr == DUT_ADDR);
        build_stream(rw, cmd, len, ack_ok);
        @(negedge CLCK);
        done0 = done_cnt; busy0 = busy_cyc; rv0 = rvalid_cnt; rx0 = rx_q.size(); stop0 = stop_cnt;
        pulse_go(rw, cmd, len);
        @(negedge CLCK);
        check({tag, " busy_after_go"}, int'(BUSY), 1);
        check({tag, " nack_cleared"}, int'(NACK), 0);
        if (inject_at > 0) begin
            repeat (inject_at) @(negedge CLCK);
            pulse_go(!rw, 8'hFF, 4'd3);
        end
        cyc = 0;
        while ((done_cnt == done0) && (cyc < LIMIT)) begin
            @(negedge CLCK);
            cyc++;
        end
        check({tag, " done_timeout"}, int'(cyc < LIMIT), 1);
        repeat (10) @(negedge CLCK);
        check({tag, " done_count"}, done_cnt - done0, 1);
        check({tag, " stop_count"}, stop_cnt - stop0, 1);
        check({tag, " nack"}, int'(NACK), int'(exp_nack));
        check({tag, " busy_cycles"}, busy_cyc - busy0, exp_ticks(rw, len, ack_ok) * CLKDIV);
        check({tag, " rvalid_count"}, rvalid_cnt - rv0, exp_nrx);
        for (int i = 0; i < exp_nrx; i++) begin
            if (rx0 + i < rx_q.size()) check({tag, " rdata"}, int'(rx_q[rx0+i]), int'(rd_data[i]));
        end
        check({tag, " stream_len"}, bits_q.size(), exp_q.size());
        first = -1;
        for (int i = 0; (i < bits_q.size()) && (i < exp_q.size()); i++) begin
            if ((first < 0) && (bits_q[i] !== exp_q[i])) first = i;
        end
        check({tag, " stream_first_diff"}, first, -1);
    endtask

    initial begin
        int cyc, done0, rv0, n;
        logic rw;
        logic [3:0] len;
        logic [6:0] sa;
        logic [7:0] fixed [8];
        fixed = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 16; i++) rd_data[i] = (i < 8) ? fixed[i] : 8'(i * 37 + 5);
        sl_addr = DUT_ADDR;
        slave_quiet = 1'b0;
        RST = 1'b1; GO = 1'b0; RW = 1'b0; CMD = 8'd0; LEN = 4'd0;

        tab[0] = '{1'b0, 8'h5A, 4'd0,  7'h72, 1'b0, 0};
        tab[1] = '{1'b1, 8'h00, 4'd8,  7'h72, 1'b0, 8};
        tab[2] = '{1'b0, 8'h5A, 4'd0,  7'h71, 1'b1, 0};
        tab[3] = '{1'b0, 8'h3C, 4'd0,  7'h72, 1'b0, 0};
        tab[4] = '{1'b1, 8'h00, 4'd0,  7'h72, 1'b0, 1};
        tab[5] = '{1'b1, 8'hA5, 4'd15, 7'h72, 1'b0, 15};
        tab[6] = '{1'b1, 8'h00, 4'd2,  7'h71, 1'b1, 0};

        repeat (3) @(negedge CLCK);
        RST = 1'b0;
        @(negedge CLCK);
        check("reset rdata", int'(RDATA), 0);
        check("reset rvalid", int'(RVALID), 0);
        check("reset busy", int'(BUSY), 0);
        check("reset done", int'(DONE), 0);
        check("reset nack", int'(NACK), 0);
        check("reset scl_released", int'(SCL === 1'b1), 1);
        check("reset sda_released", int'(SDA === 1'b1), 1);

        for (int v = 0; v < 7; v++) begin
            run_xfer($sformatf("tab%0d", v), tab[v].rw, tab[v].cmd, tab[v].len, tab[v].saddr,
                     tab[v].exp_nack, tab[v].exp_nrx, 0);
        end

        // a second GO mid-transfer must not disturb the write of 0x5A
        run_xfer("busy_go", 1'b0, 8'h5A, 4'd0, DUT_ADDR, 1'b0, 0, 60);

        // reset while the third byte of an eight-byte read is in flight
        sl_addr = DUT_ADDR;
        @(negedge CLCK);
        done0 = done_cnt; rv0 = rvalid_cnt;
        pulse_go(1'b1, 8'h00, 4'd8);
        cyc = 0;
        while ((rvalid_cnt < rv0 + 2) && (cyc < LIMIT)) begin
            @(negedge CLCK);
            cyc++;
        end
        check("rst_mid two_bytes_seen", int'(cyc < LIMIT), 1);
        repeat (40) @(negedge CLCK);
        #2;
        slave_quiet = 1'b1;
        RST = 1'b1;
        #1;
        check("rst_mid scl_released", int'(SCL === 1'b1), 1);
        check("rst_mid sda_released", int'(SDA === 1'b1), 1);
        check("rst_mid busy", int'(BUSY), 0);
        check("rst_mid rdata", int'(RDATA), 0);
        check("rst_mid rvalid", int'(RVALID), 0);
        check("rst_mid done", int'(DONE), 0);
        check("rst_mid nack", int'(NACK), 0);
        repeat (3) @(negedge CLCK);
        RST = 1'b0;
        slave_quiet = 1'b0;
        repeat (4) @(negedge CLCK);
        check("rst_mid no_done", done_cnt - done0, 0);
        run_xfer("after_rst", 1'b0, 8'hC3, 4'd0, DUT_ADDR, 1'b0, 0, 0);

        // randomized transactions checked against the reference model
        for (int r = 0; r < 8; r++) begin
            rw  = 1'($urandom_range(0, 1));
            len = 4'($urandom_range(0, 15));
            sa  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DUT_ADDR;
            for (int i = 0; i < 16; i++) rd_data[i] = 8'($urandom);
            n = (rw && (sa == DUT_ADDR)) ? n_bytes(len) : 0;
            run_xfer($sformatf("rnd%0d", r), rw, 8'($urandom), len, sa, sa != DUT_ADDR, n, 0);
        end

        check("done_busy_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
